lc3b_fetch: RTL and testbench

LC3B_FETCH -- requirements
Module: lc3b_fetch

---
 rtl/lc3b_fetch_pkg.sv | 38 +++
 rtl/lc3b_fetch_if.sv | 45 ++++
 rtl/lc3b_fetch_plus2.sv | 12 +
 rtl/lc3b_fetch.sv | 110 +++++++++++
 tb/tb_lc3b_fetch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_fetch_pkg.sv
// Shared LC-3b types: word, opcode and the fetch FSM state.
// Used by lc3b_fetch (LC3B_FETCH_STATS_EN adds fetch_count).
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_REQ,
    S_DRAIN,
    S_HOLD
  } lc3b_fetch_state;

  function automatic lc3b_word align(
    input lc3b_word a
  );
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/lc3b_fetch_if.sv
// Fetch-unit bus bundle: memory side, redirect and downstream.
// LC3B_FETCH_STATS_EN adds the fetch_count signal.
interface lc3b_fetch_if;
  import lc3b_types::*;

  lc3b_word   mem_address;
  logic       mem_read;
  lc3b_word   mem_rdata;
  logic       mem_resp;
  logic       redirect_valid;
  lc3b_word   redirect_pc;
  logic       out_valid;
  logic       out_ready;
  lc3b_word   out_ir;
  lc3b_opcode out_opcode;
  lc3b_word   out_pc;
`ifdef LC3B_FETCH_STATS_EN
  lc3b_word   fetch_count;
`endif

  modport master (
    output mem_address, mem_read,
    input  mem_rdata, mem_resp,
    input  redirect_valid, redirect_pc,
    output out_valid, out_ir,
    output out_opcode, out_pc,
`ifdef LC3B_FETCH_STATS_EN
    output fetch_count,
`endif
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_read,
    output mem_rdata, mem_resp,
    output redirect_valid, redirect_pc,
    input  out_valid, out_ir,
    input  out_opcode, out_pc,
`ifdef LC3B_FETCH_STATS_EN
    input  fetch_count,
`endif
    output out_ready
  );

endinterface

// File: rtl/lc3b_fetch_plus2.sv
// LC-3b PC incrementer: in + 2, wrapping modulo 2^16.
// Instantiated by lc3b_fetch.
module plus2
  import lc3b_types::*;
(
  input  lc3b_word in,
  output lc3b_word out
);

  assign out = in + 16'd2;

endmodule

// File: rtl/lc3b_fetch.sv
// LC-3b instruction fetch: one outstanding read, redirect, hold.
// LC3B_FETCH_STATS_EN adds a 16-bit handshake counter.
module lc3b_fetch
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic       clk,
  input  logic       reset_n,
  output lc3b_word   mem_address,
  output logic       mem_read,
  input  lc3b_word   mem_rdata,
  input  logic       mem_resp,
  input  logic       redirect_valid,
  input  lc3b_word   redirect_pc,
  output logic       out_valid,
  input  logic       out_ready,
  output lc3b_word   out_ir,
  output lc3b_opcode out_opcode,
`ifdef LC3B_FETCH_STATS_EN
  output lc3b_word   fetch_count,
`endif
  output lc3b_word   out_pc
);

  lc3b_fetch_state state, state_d;
  lc3b_word pc, pc_d, pc_inc;
  lc3b_word pending, pending_d;
  logic load;

  plus2 u_plus2 (
    .in  (pc),
    .out (pc_inc)
  );

  assign mem_address = pc;
  assign mem_read    = reset_n && (state != S_HOLD);
  assign out_valid   = reset_n && (state == S_HOLD);
  assign out_opcode  = lc3b_opcode'(out_ir[15:12]);

  // State, PC, pending redirect and output latch registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_REQ;
      pc      <= align(RESET_PC);
      pending <= '0;
      out_ir  <= '0;
      out_pc  <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      pending <= pending_d;
      if (load) begin
        out_ir <= mem_rdata;
        out_pc <= pc_inc;
      end
    end
  end

  // Next state; an issued read always completes before refetch
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pending_d = pending;
    load      = 1'b0;
    unique case (state)
      S_REQ: begin
        if (mem_resp && redirect_valid) begin
          pc_d = align(redirect_pc);
        end else if (mem_resp) begin
          load    = 1'b1;
          pc_d    = pc_inc;
          state_d = S_HOLD;
        end else if (redirect_valid) begin
          pending_d = align(redirect_pc);
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (redirect_valid)
          pending_d = align(redirect_pc);
        if (mem_resp) begin
          pc_d    = redirect_valid ?
                    align(redirect_pc) : pending;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = align(redirect_pc);
          state_d = S_REQ;
        end else if (out_ready) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

`ifdef LC3B_FETCH_STATS_EN
  // Count accepted instructions; discarded ones do not count
  always_ff @(posedge clk) begin
    if (!reset_n)
      fetch_count <= '0;
    else if (out_valid && out_ready && !redirect_valid)
      fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lc3b_fetch.sv
// Self-checking bench for lc3b_fetch (vector table + scoreboard).
// Checks fetch_count when LC3B_FETCH_STATS_EN is defined.
module tb_lc3b_fetch;
  import lc3b_types::*;

  typedef struct {
    lc3b_word   data;
    int         lat;
    int         hold;
    lc3b_opcode op;
  } vec_t;

  typedef struct {
    lc3b_word   ir;
    lc3b_word   pc;
    lc3b_opcode op;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  lc3b_fetch_if bus ();

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  exp_t cur;
  lc3b_word pc_m;
  lc3b_word cnt_exp;

  always #5 clk = ~clk;

  lc3b_fetch #(
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_address    (bus.mem_address),
    .mem_read       (bus.mem_read),
    .mem_rdata      (bus.mem_rdata),
    .mem_resp       (bus.mem_resp),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .out_valid      (bus.out_valid),
    .out_ready      (bus.out_ready),
    .out_ir         (bus.out_ir),
    .out_opcode     (bus.out_opcode),
`ifdef LC3B_FETCH_STATS_EN
    .fetch_count    (bus.fetch_count),
`endif
    .out_pc         (bus.out_pc)
  );

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h",
               name, act, req);
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef LC3B_FETCH_STATS_EN
    check(name, 32'(bus.fetch_count), 32'(cnt_exp));
`endif
  endtask

  task automatic req_state(input string name);
    check({name, "_rd"}, 32'(bus.mem_read), 1);
    check({name, "_addr"}, 32'(bus.mem_address),
          32'(pc_m));
    check({name, "_vld"}, 32'(bus.out_valid), 0);
  endtask

  task automatic to_hold(
    input lc3b_word data,
    input int lat,
    input lc3b_opcode op
  );
    exp_t e;
    e.ir = data;
    e.pc = pc_m + 16'd2;
    e.op = op;
    sb.push_back(e);
    for (int i = 1; i <= lat; i++) begin
      req_state("req");
      bus.mem_resp  = (i == lat);
      bus.mem_rdata = (i == lat) ? data : 16'hDEAD;
      @(negedge clk);
    end
    bus.mem_resp = 1'b0;
    pc_m = pc_m + 16'd2;
    check("hold_vld", 32'(bus.out_valid), 1);
    check("hold_rd", 32'(bus.mem_read), 0);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      cur = sb.pop_front();
      check("ir", 32'(bus.out_ir), 32'(cur.ir));
      check("pc", 32'(bus.out_pc), 32'(cur.pc));
      check("op", 32'(bus.out_opcode), 32'(cur.op));
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("stall_vld", 32'(bus.out_valid), 1);
      check("stall_rd", 32'(bus.mem_read), 0);
      check("stall_ir", 32'(bus.out_ir), 32'(cur.ir));
      check("stall_pc", 32'(bus.out_pc), 32'(cur.pc));
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    cnt_exp = cnt_exp + 16'd1;
    check_cnt("cnt_acc");
  endtask

  task automatic hold_redirect(input lc3b_word tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    bus.out_ready      = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    pc_m = {tgt[15:1], 1'b0};
    req_state("hredir");
    check_cnt("cnt_hredir");
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h1234, 3, 0, op_add};
    vecs[1] = '{16'h5A5A, 1, 0, op_and};
    vecs[2] = '{16'hE00F, 2, 5, op_lea};
    vecs[3] = '{16'hF025, 1, 2, op_trap};
    vecs[4] = '{16'h0E03, 4, 1, op_br};
    vecs[5] = '{16'h6283, 1, 0, op_ldr};

    reset_n            = 1'b0;
    bus.mem_rdata      = '0;
    bus.mem_resp       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    cnt_exp            = '0;
    pc_m               = 16'h0000;

    repeat (2) @(negedge clk);
    check("rst_rd", 32'(bus.mem_read), 0);
    check("rst_vld", 32'(bus.out_valid), 0);
    check("rst_ir", 32'(bus.out_ir), 0);
    check("rst_pc", 32'(bus.out_pc), 0);
    check_cnt("rst_cnt");
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      to_hold(vecs[i].data, vecs[i].lat, vecs[i].op);
      stall(vecs[i].hold);
      accept();
    end

    to_hold(16'h2ABC, 2, op_ldb);
    stall(5);
    accept();

    // two redirects while a read is outstanding
    req_state("dr0");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h3001;
    @(negedge clk);
    req_state("dr1");
    bus.redirect_pc = 16'h4000;
    @(negedge clk);
    req_state("dr2");
    bus.redirect_valid = 1'b0;
    bus.mem_resp       = 1'b1;
    bus.mem_rdata      = 16'hBEEF;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    pc_m = 16'h4000;
    req_state("dr3");
    check_cnt("dr_cnt");

    // redirect coincident with response in S_REQ
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h2345;
    bus.mem_resp       = 1'b1;
    bus.mem_rdata      = 16'hBEEF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.mem_resp       = 1'b0;
    pc_m = 16'h2344;
    req_state("co");

    // redirect with out_ready in S_HOLD
    to_hold(16'h9ABC, 1, op_not);
    hold_redirect(16'h2000);

    // wrap of the incremented PC
    to_hold(16'hC1C0, 2, op_jmp);
    hold_redirect(16'hFFFF);
    to_hold(16'h1111, 1, op_add);
    check("wrap_pc", 32'(bus.out_pc), 0);
    accept();
    req_state("wrap");

    // reset while draining
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h5000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    req_state("rd_drain");
    reset_n = 1'b0;
    @(negedge clk);
    check("rdr_rd", 32'(bus.mem_read), 0);
    check("rdr_vld", 32'(bus.out_valid), 0);
    cnt_exp = '0;
    check_cnt("rdr_cnt");
    reset_n = 1'b1;
    pc_m = 16'h0000;
    @(negedge clk);
    req_state("rdr_rel");
    to_hold(16'h3456, 2, op_stb);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
